cal_tpsram_param: RTL

Parametrised two-port (one write, one read) synchronous RAM for the calibrator datapath, the successor to the fixed 512x38 calibration buffer. It adds configurable width and depth, selectable read latency (1 or 2 cycles), optional read-during-write forwarding, a read-valid strobe, and a hardware clear engine. The clear engine zeroes the whole array after reset or on request. It sits between the calibration accumulators (write side) and the readout/packetiser (read side), single clock domain.

---
 rtl/cal_tpsram_param_if.sv | 17 +
 rtl/cal_tpsram_param.sv | 81 ++++++++
 2 files changed

// File: rtl/cal_tpsram_param_if.sv
// cal_tpsram_param_if: write/read/clear bus of the calibrator two-port RAM.
interface cal_tpsram_param_if #(
  parameter int DATA_W = 38,
  parameter int ADDR_W = 9
);
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              clr_req;
  logic              busy;
  modport master (output w_en, w_addr, w_data, r_en, r_addr, clr_req, input r_data, r_valid, busy);
  modport slave  (input w_en, w_addr, w_data, r_en, r_addr, clr_req, output r_data, r_valid, busy);
endinterface

// File: rtl/cal_tpsram_param.sv
// cal_tpsram_param: 1W1R sync RAM with 1/2-cycle read latency, write forwarding and a clear engine.
module cal_tpsram_param #(
  parameter int DATA_W = 38,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512,
  parameter int RD_LAT = 2,
  parameter int WR_FWD = 1
) (
  input logic clk,
  input logic rst_n,
  cal_tpsram_param_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  if (DATA_W < 1 || DATA_W > 64 || DEPTH < 2 || DEPTH > 2 ** ADDR_W || (RD_LAT != 1 && RD_LAT != 2)) begin : g_bad_param
    $error("cal_tpsram_param: illegal parameter combination");
  end
  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;
  state_t state, state_nx;
  logic [AW-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic clr_last, clr_we, wr_ok, rd_ok, busy, fwd, r_in;
  logic [DATA_W-1:0] rd_word, s1_data;
  logic s1_valid;
  assign clr_last = clr_addr == LAST;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= (state == CLEAR && !clr_last) ? clr_addr + 1'b1 : '0;
    end
  end
  always_comb state_nx = (state == CLEAR) ? (clr_last ? IDLE : CLEAR) : (bus.clr_req ? CLEAR : IDLE);
  always_comb begin
    busy   = state == CLEAR || !rst_n;
    clr_we = rst_n && state == CLEAR;
    wr_ok  = rst_n && state == IDLE && bus.w_en && ({1'b0, bus.w_addr} < LIM);
    rd_ok  = rst_n && state == IDLE && bus.r_en;
  end
  assign bus.busy = busy;
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_addr] <= '0;
    else if (wr_ok) mem[bus.w_addr[AW-1:0]] <= bus.w_data;
  end
  // out-of-range reads still complete, carrying zero data
  always_comb begin
    r_in    = {1'b0, bus.r_addr} < LIM;
    fwd     = WR_FWD != 0 && wr_ok && bus.w_addr == bus.r_addr;
    rd_word = !r_in ? '0 : fwd ? bus.w_data : mem[bus.r_addr[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_ok;
      if (rd_ok) s1_data <= rd_word;
    end
  end
  if (RD_LAT == 1) begin : g_lat1
    assign bus.r_valid = s1_valid;
    assign bus.r_data  = s1_data;
  end else begin : g_lat2
    logic v2;
    logic [DATA_W-1:0] d2;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= s1_valid;
        if (s1_valid) d2 <= s1_data;
      end
    end
    assign bus.r_valid = v2;
    assign bus.r_data  = d2;
  end
endmodule
